// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acc_sequencer
// Brief    : Sequences an external register+adder accumulator through an
//            N-term reduction and returns the sum on a valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
module acc_sequencer #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
  input  logic [MAC_ACC_WIDTH-1:0] cfg_init,
  input  logic                     cfg_abort,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAC_ACC_WIDTH-1:0] in_data,
  output logic                     acc_en,
  output logic                     acc_cset,
  output logic [MAC_ACC_WIDTH-1:0] acc_init,
  output logic                     acc_carry_in,
  output logic [MAC_ACC_WIDTH-1:0] acc_in,
  input  logic                     acc_carry_out,
  input  logic [MAC_ACC_WIDTH-1:0] acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MAC_ACC_WIDTH-1:0] out_data,
  output logic                     out_overflow
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_ACCUM = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [LEN_WIDTH-1:0] c_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]               r_state;
  logic [LEN_WIDTH-1:0]     r_count;
  logic [MAC_ACC_WIDTH-1:0] r_init;
  logic                     r_ovf;
  logic                     w_take;

  // Abort masks in_ready combinationally so a product offered alongside it is refused.
  assign in_ready     = (r_state == c_ACCUM) && !cfg_abort;
  assign w_take       = in_valid && in_ready;
  assign acc_en       = w_take;
  assign acc_cset     = (r_state == c_LOAD);
  assign acc_init     = r_init;
  assign acc_carry_in = 1'b0;
  assign acc_in       = in_data;
  assign busy         = (r_state != c_IDLE);
  assign out_valid    = (r_state == c_DONE);
  assign out_data     = out_valid ? acc_out : '0;
  assign out_overflow = out_valid && r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_init  <= '0;
      r_ovf   <= 1'b0;
    end else if (cfg_abort && r_state != c_IDLE) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (cfg_start) begin
            r_count <= cfg_len;
            r_init  <= cfg_init;
            r_ovf   <= 1'b0;
            r_state <= c_LOAD;
          end
        end
        c_LOAD: begin
          r_state <= (r_count != '0) ? c_ACCUM : c_DRAIN;
        end
        c_ACCUM: begin
          if (w_take) begin
            r_count <= r_count - c_ONE;
            r_ovf   <= r_ovf | acc_carry_out;
            if (r_count == c_ONE) begin
              r_state <= c_DRAIN;
            end
          end
        end
        c_DRAIN: begin
          // One cycle for the accumulator register to absorb the final add.
          r_state <= c_DONE;
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_sequencer
// Brief    : Directed, table-driven bench for acc_sequencer with an attached
//            register+adder accumulator model.
// Revision : 1.0  initial release
// ============================================================================
module tb_acc_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [7:0]    cfg_len;
  logic [W-1:0]  cfg_init;
  logic          cfg_abort;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          acc_en;
  logic          acc_cset;
  logic [W-1:0]  acc_init;
  logic          acc_carry_in;
  logic [W-1:0]  acc_in;
  logic          acc_carry_out;
  logic [W-1:0]  acc_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_overflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  acc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_len       (cfg_len),
    .cfg_init      (cfg_init),
    .cfg_abort     (cfg_abort),
    .busy          (busy),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .acc_en        (acc_en),
    .acc_cset      (acc_cset),
    .acc_init      (acc_init),
    .acc_carry_in  (acc_carry_in),
    .acc_in        (acc_in),
    .acc_carry_out (acc_carry_out),
    .acc_out       (acc_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_overflow  (out_overflow)
  );

  // Accumulator datapath the sequencer drives: register plus adder, carry combinational.
  logic [W:0] w_sum;
  assign w_sum         = {1'b0, acc_out} + {1'b0, acc_in} + {{W{1'b0}}, acc_carry_in};
  assign acc_carry_out = w_sum[W];
  always_ff @(posedge clk) begin
    if (rst)           acc_out <= '0;
    else if (acc_cset) acc_out <= acc_init;
    else if (acc_en)   acc_out <= w_sum[W-1:0];
  end

  typedef struct {
    logic [W-1:0]        init;
    logic [7:0]          len;
    logic [3:0][W-1:0]   prod;
    int                  gap;
    int                  rd;
    logic [W-1:0]        exp_data;
    logic                exp_ovf;
  } job_t;

  job_t jobs[5];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_job(input job_t j);
    cfg_start = 1'b1; cfg_len = j.len; cfg_init = j.init;
    tick();
    cfg_start = 1'b0;
    #1;
    chk("load_cset", {31'b0, acc_cset}, 1);
    chk("load_init", acc_init, j.init);
    chk("load_busy", {31'b0, busy}, 1);
    chk("load_in_ready", {31'b0, in_ready}, 0);
    tick();
    for (int i = 0; i < int'(j.len); i++) begin
      for (int g = 0; g < j.gap; g++) begin
        in_valid = 1'b0;
        #1;
        chk("stall_ready", {31'b0, in_ready}, 1);
        chk("stall_en", {31'b0, acc_en}, 0);
        tick();
      end
      in_valid = 1'b1; in_data = j.prod[i];
      #1;
      chk("accum_en", {31'b0, acc_en}, 1);
      chk("accum_pass", acc_in, j.prod[i]);
      tick();
      in_valid = 1'b0;
    end
    #1;
    chk("drain_ready", {31'b0, in_ready}, 0);
    chk("drain_valid", {31'b0, out_valid}, 0);
    tick();
    for (int r = 0; r < j.rd; r++) begin
      out_ready = 1'b0;
      #1;
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_data", out_data, j.exp_data);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("done_valid", {31'b0, out_valid}, 1);
    chk("done_data", out_data, j.exp_data);
    chk("done_ovf", {31'b0, out_overflow}, {31'b0, j.exp_ovf});
    tick();
    out_ready = 1'b0;
    #1;
    chk("post_valid", {31'b0, out_valid}, 0);
    chk("post_busy", {31'b0, busy}, 0);
  endtask

  initial begin
    jobs[0] = '{init: 32'd10, len: 8'd3, prod: {32'd0, 32'd3, 32'd2, 32'd1},
                gap: 0, rd: 0, exp_data: 32'd16, exp_ovf: 1'b0};
    jobs[1] = '{init: 32'hDEADBEEF, len: 8'd0, prod: '0,
                gap: 0, rd: 0, exp_data: 32'hDEADBEEF, exp_ovf: 1'b0};
    jobs[2] = '{init: 32'hFFFFFFF0, len: 8'd2, prod: {32'd0, 32'd0, 32'h10, 32'h8},
                gap: 0, rd: 0, exp_data: 32'h00000008, exp_ovf: 1'b1};
    jobs[3] = '{init: 32'd0, len: 8'd1, prod: {32'd0, 32'd0, 32'd0, 32'd5},
                gap: 0, rd: 0, exp_data: 32'd5, exp_ovf: 1'b0};
    jobs[4] = '{init: 32'd100, len: 8'd4, prod: {32'h44, 32'h33, 32'h22, 32'h11},
                gap: 2, rd: 5, exp_data: 32'd270, exp_ovf: 1'b0};

    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_init = '0; cfg_abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_acc_en", {31'b0, acc_en}, 0);
    chk("rst_cset", {31'b0, acc_cset}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_ovf", {31'b0, out_overflow}, 0);
    chk("rst_acc_init", acc_init, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_carry_in", {31'b0, acc_carry_in}, 0);
    tick();

    for (int k = 0; k < 5; k++) run_job(jobs[k]);

    // Abort after two of four products; a stray start mid-job must be ignored.
    cfg_start = 1'b1; cfg_len = 8'd4; cfg_init = 32'd50;
    tick();
    cfg_start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    cfg_start = 1'b1; cfg_len = 8'd0; cfg_init = 32'h12345678;
    tick();
    cfg_start = 1'b0;
    #1;
    chk("start_ignored_ready", {31'b0, in_ready}, 1);
    chk("start_ignored_cset", {31'b0, acc_cset}, 0);
    cfg_abort = 1'b1; in_valid = 1'b1; in_data = 32'd99;
    #1;
    chk("abort_ready", {31'b0, in_ready}, 0);
    chk("abort_en", {31'b0, acc_en}, 0);
    tick();
    cfg_abort = 1'b0; in_valid = 1'b0;
    #1;
    chk("abort_idle", {31'b0, busy}, 0);
    chk("abort_no_result", {31'b0, out_valid}, 0);
    tick();
    chk("abort_still_idle", {31'b0, busy}, 0);
    run_job('{init: 32'd0, len: 8'd1, prod: {32'd0, 32'd0, 32'd0, 32'd7},
              gap: 0, rd: 0, exp_data: 32'd7, exp_ovf: 1'b0});

    // Abort in DONE outranks a simultaneous out_ready.
    cfg_start = 1'b1; cfg_len = 8'd0; cfg_init = 32'd9;
    tick();
    cfg_start = 1'b0;
    tick(); tick();
    #1;
    chk("done_pre_abort", {31'b0, out_valid}, 1);
    cfg_abort = 1'b1; out_ready = 1'b1;
    tick();
    cfg_abort = 1'b0; out_ready = 1'b0;
    #1;
    chk("done_abort_valid", {31'b0, out_valid}, 0);
    chk("done_abort_busy", {31'b0, busy}, 0);

    // Reset while holding a result.
    cfg_start = 1'b1; cfg_len = 8'd0; cfg_init = 32'd3;
    tick();
    cfg_start = 1'b0;
    tick(); tick();
    #1;
    chk("rst_done_pre", {31'b0, out_valid}, 1);
    chk("rst_done_data", out_data, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_done_valid", {31'b0, out_valid}, 0);
    chk("rst_done_busy", {31'b0, busy}, 0);
    chk("rst_done_out", out_data, 0);
    tick();
    run_job(jobs[3]);
    run_job(jobs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Controller that sequences one accumulate datapath instance (register + adder, with en/cset/init/carry controls) to compute a length-N reduction of MAC products.
- Sits between the multiplier stage and the result consumer. Loads the initial/bias value, gates `en` per accepted product, tracks unsigned overflow, and presents the final sum on a valid/ready output.

Parameters:
- MAC_MIN_WIDTH, 8, minimum MAC operand width.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, accumulator and product width.
- LEN_WIDTH, 8, width of the term-count configuration.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  one-cycle start pulse; sampled only in IDLE.
- cfg_len  input  LEN_WIDTH  number of terms N; captured on an accepted start.
- cfg_init  input  MAC_ACC_WIDTH  initial value; captured on an accepted start.
- cfg_abort  input  1  cancels the current job.
- busy  output  1  high in any state other than IDLE.
- in_valid  input  1  product valid.
- in_ready  output  1  sequencer accepts a product.
- in_data  input  MAC_ACC_WIDTH  product value.
- acc_en  output  1  to accumulator `en`.
- acc_cset  output  1  to accumulator `cset`.
- acc_init  output  MAC_ACC_WIDTH  to accumulator `init`.
- acc_carry_in  output  1  to accumulator `carry_in`; constant 0.
- acc_in  output  MAC_ACC_WIDTH  to accumulator `acc_in`.
- acc_carry_out  input  1  from accumulator `carry_out`.
- acc_out  input  MAC_ACC_WIDTH  from accumulator `out` (registered sum).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  MAC_ACC_WIDTH  final sum.
- out_overflow  output  1  sticky unsigned overflow seen during the job.

Behaviour:
- Reset (synchronous):
  - state = IDLE, counter = 0, overflow flag = 0.
  - busy, in_ready, acc_en, acc_cset, out_valid, out_overflow = 0.
  - acc_init and out_data = 0.
- FSM states: IDLE, LOAD, ACCUM, DRAIN, DONE.
- IDLE:
  - On cfg_start=1: capture cfg_len into the counter and cfg_init into a register; clear the overflow flag; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - acc_cset=1 and acc_init = captured init.
  - Next state is ACCUM if the counter ≠ 0, else DRAIN.
  - Accumulator holds init one cycle later.
- ACCUM:
  - in_ready=1; acc_in = in_data (combinational pass-through).
  - acc_en = in_valid & in_ready.
  - Each handshake: decrement the counter; overflow flag |= acc_carry_out.
  - When the handshake occurs with counter == 1, go to DRAIN.
  - in_valid=0 stalls indefinitely with acc_en=0 (accumulator holds).
- DRAIN (1 cycle):
  - in_ready=0, acc_en=0.
  - Allows acc_out to reflect the last add; go to DONE.
- DONE:
  - out_valid=1; out_data = acc_out; out_overflow = overflow flag. acc_out is stable because en=0 and cset=0.
  - On out_ready=1: go to IDLE.
  - Result held stable while out_ready=0.
- Latency: N=0 returns out_valid=cfg_init 3 cycles after start (start, LOAD, DRAIN → DONE).
  - With no stalls, out_valid rises 2 cycles after the last input handshake.
- cfg_start outside IDLE: ignored.
- cfg_abort in any non-IDLE state:
  - Next state is IDLE; out_valid and in_ready drop the next cycle.
  - A product presented in the same cycle is not accepted (in_ready is forced to 0 that cycle).
  - The accumulator is not cleared; the next LOAD overwrites it.
- Simultaneous events:
  - rst has priority over all other inputs.
  - cfg_abort has priority over cfg_start and out_ready.
- Wrap-around: the sum wraps modulo 2^MAC_ACC_WIDTH and overflow is flagged. acc_carry_in is always 0.
- Reset mid-job: returns to IDLE without producing a result. The accumulator is cleared by its own rst when the same rst is shared.

Test Plan:
- start, init=10, N=3, products 1,2,3 back-to-back, out_ready=1 → out_data=16, out_overflow=0, out_valid exactly 1 cycle, busy low the next cycle.
- N=0, init=0xDEADBEEF → no in_ready; out_data=0xDEADBEEF 3 cycles after start.
- init=0xFFFFFFF0, N=2, products 0x8, 0x10 → out_data=0x00000008, out_overflow=1. Next job, init=0, N=1, product 5 → out_data=5, out_overflow=0.
- N=4 with in_valid gapped (idle cycles between products), out_ready held low 5 cycles → sum correct; out_data/out_valid stable throughout the backpressure.
- Abort in ACCUM after 2 of 4 products, then new start with init=0, N=1, product 7 → no result for the aborted job; result 7. A cfg_start issued mid-job is ignored.
- rst asserted in DONE → out_valid=0 next cycle, state IDLE; a subsequent job behaves normally.
